// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Initiator-side controller for a single-port synchronous RAM with a
//   registered read. It accepts one read or write per valid/ready handshake,
//   drives the RAM pins from registers, and returns read data with a
//   one-cycle rsp_valid strobe.
//
//   Optional feature macro: RAM_ACCESS_CTRL_INIT_EN
//     defined   : after reset the whole array is written with INIT_VALUE,
//                 one address per cycle, before any request is accepted.
//     undefined : the controller comes out of reset directly in IDLE.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake; req_we selects write (1) / read (0)
//   req_addr/wdata    request address and write data
//   rsp_valid/rdata   one-cycle read-response strobe and held read data
//   busy              controller not in IDLE
//   init_done         array clear finished (always 1 after reset without macro)
//   ram_*             registered RAM pins; ram_q is the RAM's registered output
module ram_access_ctrl #(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter int unsigned            ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  init_done,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_en,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_q
);

`ifdef RAM_ACCESS_CTRL_INIT_EN
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_CAPTURE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_CAPTURE
  } state_e;
`endif

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;
  logic                  init_done_q, init_done_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic                  accept;

  // req_ready_q is only ever high while in IDLE, so it alone qualifies an accept.
  assign accept = req_valid && req_ready_q;

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    ram_address_d = ram_address_q;
    ram_data_d    = '0;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
`ifdef RAM_ACCESS_CTRL_INIT_EN
    cnt_d         = cnt_q;
    init_done_d   = init_done_q;
`else
    init_done_d   = 1'b1;
`endif

    case (state_q)
`ifdef RAM_ACCESS_CTRL_INIT_EN
      ST_INIT: begin
        ram_address_d = cnt_q;
        ram_data_d    = INIT_VALUE;
        ram_en_d      = 1'b1;
        ram_we_d      = 1'b1;
        if (cnt_q == '1) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      ST_IDLE: begin
        if (accept) begin
          ram_address_d = req_addr;
          ram_en_d      = 1'b1;
          if (req_we) begin
            ram_data_d = req_wdata;
            ram_we_d   = 1'b1;
            state_d    = ST_WRITE;
          end else begin
            state_d    = ST_RD_ISSUE;
          end
        end
      end
      ST_WRITE:    state_d = ST_IDLE;
      ST_RD_ISSUE: state_d = ST_RD_CAPTURE;
      ST_RD_CAPTURE: begin
        rsp_rdata_d = ram_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state register rather than lagging it by a cycle.
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef RAM_ACCESS_CTRL_INIT_EN
      state_q <= ST_INIT;
      cnt_q   <= '0;
`else
      state_q <= ST_IDLE;
`endif
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b1;
      init_done_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      ram_data_q    <= '0;
      ram_address_q <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
    end else begin
`ifdef RAM_ACCESS_CTRL_INIT_EN
      cnt_q <= cnt_d;
`endif
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      init_done_q   <= init_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      ram_data_q    <= ram_data_d;
      ram_address_q <= ram_address_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign busy             = busy_q;
  assign init_done        = init_done_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign ram_data         = ram_data_q;
  assign ram_address      = ram_address_q;
  assign ram_en           = ram_en_q;
  assign ram_write_enable = ram_we_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl: behavioural 64x8 RAM as environment,
// array reference model plus response scoreboard with latency tracking.
module tb_ram_access_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam logic [DW-1:0] INIT_V = 8'hC3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          init_done;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_address;
  logic          ram_en;
  logic          ram_write_enable;
  logic [DW-1:0] ram_q = '0;

  always #5 clk = ~clk;

  ram_access_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .INIT_VALUE (INIT_V)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .busy             (busy),
    .init_done        (init_done),
    .ram_data         (ram_data),
    .ram_address      (ram_address),
    .ram_en           (ram_en),
    .ram_write_enable (ram_write_enable),
    .ram_q            (ram_q)
  );

  // Environment: single-port RAM with registered read.
  logic [DW-1:0] ram [DEPTH];
  int unsigned   ram_wr_cnt = 0;
  int unsigned   cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      if (ram_write_enable) begin
        ram[ram_address] <= ram_data;
        ram_wr_cnt       <= ram_wr_cnt + 1;
      end else begin
        ram_q <= ram[ram_address];
      end
    end
  end

  // Reference model and scoreboard.
  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
    int unsigned   addr;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model [DEPTH];
  int            n_vec  = 0;
  int            n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every response must match the oldest outstanding read, on time.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("rdata@%0d", e.addr), 32'(rsp_rdata), 32'(e.data));
        check($sformatf("rsp_latency@%0d", e.addr), cyc, e.due);
      end
    end
  end

  // Issue one request; returns the cycle number of the accepting edge.
  task automatic do_req(input bit we, input int unsigned addr, input logic [DW-1:0] d,
                        output int unsigned acc);
    int unsigned waited;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wdata = d;
    waited    = 0;
    acc       = 0;
    while (!req_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 50) begin
        check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    acc = cyc + 1;
    if (we) model[addr] = d;
    else exp_q.push_back('{model[addr], cyc + 3, addr});
    @(posedge clk);
  endtask

  task automatic idle(input int unsigned n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready",   32'(req_ready),        32'd0);
    check("rst_rsp_valid",   32'(rsp_valid),        32'd0);
    check("rst_rsp_rdata",   32'(rsp_rdata),        32'd0);
    check("rst_ram_en",      32'(ram_en),           32'd0);
    check("rst_ram_we",      32'(ram_write_enable), 32'd0);
    check("rst_ram_data",    32'(ram_data),         32'd0);
    check("rst_ram_address", 32'(ram_address),      32'd0);
    check("rst_busy",        32'(busy),             32'd1);
    check("rst_init_done",   32'(init_done),        32'd0);
  endtask

  // Assert reset at the next falling edge for n cycles, then release.
  task automatic apply_reset(input int unsigned n);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    repeat (n) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
  endtask

  // Bring-up after reset release (called at the falling edge of release).
  task automatic post_reset();
`ifdef RAM_ACCESS_CTRL_INIT_EN
    int unsigned n;
    // A read of @31 is held pending through the clear; it must stall.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = AW'(31);
    n = 0;
    for (int unsigned k = 0; k < 200; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (init_done) break;
      if (req_ready) check("ready_during_init", 32'(req_ready), 32'd0);
    end
    check("init_cycles", n, 32'd64);
    check("init_done_high", 32'(init_done), 32'd1);
    check("ready_after_init", 32'(req_ready), 32'd1);
    for (int unsigned a = 0; a < DEPTH; a++) model[a] = INIT_V;
    // The held request is accepted on the coming edge.
    if (req_ready) exp_q.push_back('{model[31], cyc + 3, 31});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
`else
    @(posedge clk);
    @(negedge clk);
    check("ready_first_cycle", 32'(req_ready), 32'd1);
    check("init_done_nomacro", 32'(init_done), 32'd1);
    check("busy_idle",         32'(busy),      32'd0);
`endif
  endtask

  task automatic drain();
    for (int unsigned k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int unsigned acc, prev, wc0;
    bit          we;

    apply_reset(3);
    post_reset();

`ifdef RAM_ACCESS_CTRL_INIT_EN
    do_req(1'b0, 0,  '0, acc);
    do_req(1'b0, 31, '0, acc);
    do_req(1'b0, 63, '0, acc);
`else
    // Contents are unspecified after reset: establish them first.
    for (int unsigned a = 0; a < DEPTH; a++) do_req(1'b1, a, 8'($urandom()), acc);
`endif
    idle(2);

    // Directed write/read sequence.
    do_req(1'b1, 16, 8'h18, acc);
    do_req(1'b1, 12, 8'h29, acc);
    do_req(1'b1, 7,  8'hAA, acc);
    do_req(1'b0, 16, '0, acc);
    do_req(1'b0, 12, '0, acc);
    do_req(1'b0, 7,  '0, acc);
    idle(4);

    // Back-to-back writes: one accept every 2 cycles, one RAM write each.
    wc0  = ram_wr_cnt;
    prev = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      do_req(1'b1, $urandom_range(0, 63), 8'($urandom()), acc);
      if (k > 0) check("wr_gap", acc - prev, 32'd2);
      prev = acc;
    end
    idle(3);
    check("wr_pulse_count", ram_wr_cnt - wc0, 32'd6);

    // Back-to-back reads: one accept every 3 cycles.
    for (int unsigned k = 0; k < 6; k++) begin
      do_req(1'b0, $urandom_range(0, 63), '0, acc);
      if (k > 0) check("rd_gap", acc - prev, 32'd3);
      prev = acc;
    end
    idle(4);

    // Address boundaries, read-after-write.
    do_req(1'b1, 63, 8'h55, acc);
    do_req(1'b0, 63, '0, acc);
    do_req(1'b1, 0,  8'h00, acc);
    do_req(1'b0, 0,  '0, acc);
    idle(4);

    // Randomized traffic with random gaps.
    for (int unsigned k = 0; k < 300; k++) begin
      we = 1'($urandom());
      do_req(we, $urandom_range(0, 63), 8'($urandom()), acc);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
    end
    idle(2);
    drain();

    // Reset the cycle after a read accept: that read must never respond.
    do_req(1'b0, 16, '0, acc);
    apply_reset(1);
    post_reset();
    idle(8);
    do_req(1'b0, 16, '0, acc);
    do_req(1'b1, 5, 8'h3C, acc);
    do_req(1'b0, 5, '0, acc);
    idle(2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
